// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_divider                                                  |
// | Description : Multi-cycle restoring divider. One shift-and-subtract step   |
// |               per clock on a WIDTH+1-bit accumulator; the borrow of the    |
// |               trial subtraction decides whether the accumulator restores.  |
// |               Optional build macro DIV_SIGNED_EN selects two's-complement  |
// |               truncating division (magnitudes in, sign fix-up on output).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ovfl
);

  // Counter must be able to hold the value WIDTH.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   acc;        // partial remainder (A)
  logic [WIDTH-1:0] q_reg;      // dividend being shifted out / quotient shifted in (Q)
  logic [WIDTH-1:0] d_reg;      // divisor magnitude (D)
  logic [CW-1:0]    count;      // completed iterations
  logic             dbz_pend;   // operation in flight is a divide by zero
  logic             ovfl_pend;  // operation in flight overflows (signed MIN / -1)
  logic             neg_q;      // quotient must be negated on completion
  logic             neg_r;      // remainder must be negated on completion

  logic             accept;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   trial;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             ovfl_case;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Two's-complement negate: invert and add one.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  // A start is taken only when idle and not in the done-pulse cycle, so a
  // new operation always begins in the cycle after done at the earliest.
  assign accept = (state == S_IDLE) && start && !done;

  // One restoring step: shift {A,Q} left, then trial-subtract D from A.
  always_comb begin
    acc_sh = (acc << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};
    trial  = acc_sh - {1'b0, d_reg};
  end

`ifdef DIV_SIGNED_EN
  // Signed build: feed magnitudes to the unsigned core and remember signs.
  always_comb begin
    dvd_neg   = dividend[WIDTH-1];
    dvs_neg   = divisor[WIDTH-1];
    dvd_mag   = dvd_neg ? negate(dividend) : dividend;
    dvs_mag   = dvs_neg ? negate(divisor) : divisor;
    // Most-negative / -1 has no representable quotient; the core naturally
    // yields MIN with remainder 0, which is what gets reported.
    ovfl_case = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == {WIDTH{1'b1}});
  end
`else
  // Unsigned build: operands pass straight through and overflow cannot occur.
  always_comb begin
    dvd_neg   = 1'b0;
    dvs_neg   = 1'b0;
    dvd_mag   = dividend;
    dvs_mag   = divisor;
    ovfl_case = 1'b0;
  end
`endif

  // Sign fix-up of the core result (truncating division: remainder follows dividend).
  always_comb begin
    q_fix = neg_q ? negate(q_reg) : q_reg;
    r_fix = neg_r ? negate(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      count       <= '0;
      dbz_pend    <= 1'b0;
      ovfl_pend   <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      ovfl        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            busy        <= 1'b1;
            acc         <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
            ovfl        <= 1'b0;
            d_reg       <= dvs_mag;
            neg_q       <= dvd_neg ^ dvs_neg;
            neg_r       <= dvd_neg;
            ovfl_pend   <= ovfl_case;
            if (divisor == '0) begin
              // Keep the raw dividend so it can be returned as the remainder.
              dbz_pend <= 1'b1;
              q_reg    <= dividend;
              state    <= S_DONE;
            end else begin
              dbz_pend <= 1'b0;
              q_reg    <= dvd_mag;
              state    <= S_RUN;
            end
          end
        end

        S_RUN: begin
          // No borrow: keep the difference and shift in a 1; else restore.
          if (!trial[WIDTH]) begin
            acc <= trial;
          end else begin
            acc <= acc_sh;
          end
          q_reg <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (dbz_pend) begin
            quotient    <= '1;
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            ovfl        <= ovfl_pend;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
